// File: rtl/ball_engine.sv
// Ball engine for the 10-LED ping-pong field: serves a one-hot ball, steps it at a
// speed-dependent rate, flags a miss past either end with the rally winner, blanks
// the field for a fixed time and then re-serves.
module ball_engine #(
    parameter int UNIT      = 12500000,
    parameter int OUT_TICKS = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed,
    input  logic       direction,
    input  logic       halt,
    input  logic       rstball,
    input  logic       ball,
    output logic [9:0] position,
    output logic       outside,
    output logic       winner
);

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        MOVE  = 2'd1,
        OUT   = 2'd2
    } state_t;

    // Last counter value of each step interval, (4-speed)*UNIT-1, and of the blank time.
    localparam logic [27:0] LAST_S0  = 28'(4 * UNIT - 1);
    localparam logic [27:0] LAST_S1  = 28'(3 * UNIT - 1);
    localparam logic [27:0] LAST_S2  = 28'(2 * UNIT - 1);
    localparam logic [27:0] LAST_S3  = 28'(1 * UNIT - 1);
    localparam logic [27:0] OUT_LAST = 28'(OUT_TICKS - 1);

    state_t      state_r, state_s;
    logic [27:0] cnt_r, cnt_s;
    logic [9:0]  pos_r, pos_s;
    logic        outside_r, outside_s;
    logic        winner_r, winner_s;
    logic        dir_r;
    logic [9:0]  serve_pos_s;
    logic [27:0] last_s;

    assign position = pos_r;
    assign outside  = outside_r;
    assign winner   = winner_r;

    // Serve LED and the step-interval terminal count for the current inputs.
    always_comb begin
        serve_pos_s = ball ? 10'h001 : 10'h200;
        case (speed)
            2'd0:    last_s = LAST_S0;
            2'd1:    last_s = LAST_S1;
            2'd2:    last_s = LAST_S2;
            2'd3:    last_s = LAST_S3;
            default: last_s = LAST_S0;
        endcase
    end

    // Next-state and next-output logic for the SERVE/MOVE/OUT sequence.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pos_s     = pos_r;
        outside_s = 1'b0;
        winner_s  = winner_r;
        if (rstball) begin
            state_s = SERVE;
            cnt_s   = 28'd0;
            pos_s   = serve_pos_s;
        end else begin
            case (state_r)
                SERVE: begin
                    pos_s = serve_pos_s;
                    cnt_s = 28'd0;
                    if (!halt) begin
                        state_s = MOVE;
                    end else begin
                        state_s = SERVE;
                    end
                end
                MOVE: begin
                    if (direction != dir_r) begin
                        // A return hit restarts the interval so it gets full time.
                        cnt_s = 28'd0;
                    end else if (halt) begin
                        cnt_s = cnt_r;
                    end else if (cnt_r >= last_s) begin
                        // >= rather than == so a speed-up mid-interval steps at once
                        // instead of letting the counter run the full 28-bit range.
                        cnt_s = 28'd0;
                        if (!direction) begin
                            if (pos_r[9]) begin
                                pos_s     = 10'h000;
                                outside_s = 1'b1;
                                winner_s  = 1'b1;
                                state_s   = OUT;
                            end else begin
                                pos_s = pos_r << 1;
                            end
                        end else begin
                            if (pos_r[0]) begin
                                pos_s     = 10'h000;
                                outside_s = 1'b1;
                                winner_s  = 1'b0;
                                state_s   = OUT;
                            end else begin
                                pos_s = pos_r >> 1;
                            end
                        end
                    end else begin
                        cnt_s = cnt_r + 28'd1;
                    end
                end
                OUT: begin
                    if (cnt_r >= OUT_LAST) begin
                        // Load the serve LED on the way out so the blank lasts exactly OUT_TICKS.
                        cnt_s   = 28'd0;
                        state_s = SERVE;
                        pos_s   = serve_pos_s;
                    end else begin
                        cnt_s = cnt_r + 28'd1;
                        pos_s = 10'h000;
                    end
                end
                default: begin
                    state_s = SERVE;
                    cnt_s   = 28'd0;
                    pos_s   = serve_pos_s;
                end
            endcase
        end
    end

    // State, counter, outputs and last-seen direction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= SERVE;
            cnt_r     <= 28'd0;
            pos_r     <= 10'h001;
            outside_r <= 1'b0;
            winner_r  <= 1'b0;
            dir_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            pos_r     <= pos_s;
            outside_r <= outside_s;
            winner_r  <= winner_s;
            dir_r     <= direction;
        end
    end

endmodule
